// File: rtl/memory_transfer_unit_if.sv
// Bus bundle for the multi-byte load/store sequencer.
// The slave modport is the sequencer side and the master modport is the requester/memory side.
interface memory_transfer_unit_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned WORD_BYTES = 4
);
   localparam int unsigned W  = 8 * WORD_BYTES;
   localparam int unsigned SW = $clog2(WORD_BYTES);

   logic                  Start;
   logic                  Write;
   logic                  Signed;
   logic [SW-1:0]         Size;
   logic [ADDR_WIDTH-1:0] BaseAddr;
   logic [W-1:0]          WData;
   logic [W-1:0]          RData;
   logic                  Busy;
   logic                  Done;
   logic [ADDR_WIDTH-1:0] Mem_Address;
   logic [7:0]            Mem_Data;
   logic                  Mem_WR;
   logic                  Mem_CS;
   logic [7:0]            MemOut;

   modport slave (
      input  Start, Write, Signed, Size, BaseAddr, WData, MemOut,
      output RData, Busy, Done, Mem_Address, Mem_Data, Mem_WR, Mem_CS
   );

   modport master (
      output Start, Write, Signed, Size, BaseAddr, WData, MemOut,
      input  RData, Busy, Done, Mem_Address, Mem_Data, Mem_WR, Mem_CS
   );
endinterface

// File: rtl/memory_transfer_unit.sv
// Multi-byte load/store sequencer between a byte-wide memory and a word-wide datapath.
// It issues Size+1 consecutive byte accesses from BaseAddr, with selectable lane order and optional load sign extension.
module memory_transfer_unit #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned WORD_BYTES = 4,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic                   Clock,
   input  logic                   Reset,
   memory_transfer_unit_if.slave  bus
);
   localparam int unsigned W  = 8 * WORD_BYTES;
   localparam int unsigned SW = $clog2(WORD_BYTES);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic                  signed_q, signed_d;
   logic [SW-1:0]         size_q, size_d;
   logic [SW-1:0]         k_q, k_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [W-1:0]          wdata_q, wdata_d;
   logic [W-1:0]          acc_q, acc_d;
   logic [W-1:0]          rdata_q, rdata_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  cs_q, cs_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            mdata_q, mdata_d;

   // Word lane that memory byte k of a Size-byte transfer maps to.
   function automatic logic [SW-1:0] lane_of(input logic [SW-1:0] k, input logic [SW-1:0] sz);
      return BIG_ENDIAN ? SW'(sz - k) : k;
   endfunction

   // Fill lanes above sz with zero, or with bit 7 of lane sz when sign extending.
   function automatic logic [W-1:0] extend(input logic [W-1:0] acc, input logic [SW-1:0] sz,
                                           input logic sgn);
      logic [W-1:0] res;
      logic         fill;
      res  = acc;
      fill = 1'b0;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         if (SW'(i) == sz) fill = sgn & acc[8*i+7];
      end
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         if (SW'(i) > sz) res[8*i +: 8] = {8{fill}};
      end
      return res;
   endfunction

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      signed_d = signed_q;
      size_d   = size_q;
      k_d      = k_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      acc_d    = acc_q;
      rdata_d  = rdata_q;

      case (state_q)
         XFER: begin
            if (!write_q) begin
               for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                  if (SW'(i) == lane_of(k_q, size_q)) acc_d[8*i +: 8] = bus.MemOut;
               end
            end
            if (k_q == size_q) begin
               state_d = DONE;
               if (!write_q) rdata_d = extend(acc_d, size_q, signed_q);
            end else begin
               k_d = k_q + SW'(1);
            end
         end
         // IDLE and DONE both accept a new request
         default: begin
            state_d = IDLE;
            if (bus.Start) begin
               state_d  = XFER;
               write_d  = bus.Write;
               signed_d = bus.Signed;
               size_d   = bus.Size;
               base_d   = bus.BaseAddr;
               wdata_d  = bus.WData;
               k_d      = '0;
               acc_d    = '0;
            end
         end
      endcase

      // Outputs are registered, so derive them from the upcoming state and byte index
      busy_d  = (state_d == XFER);
      done_d  = (state_d == DONE);
      cs_d    = !busy_d;
      wr_d    = busy_d & write_d;
      addr_d  = busy_d ? ADDR_WIDTH'(base_d + ADDR_WIDTH'(k_d)) : '0;
      mdata_d = '0;
      if (wr_d) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (SW'(i) == lane_of(k_d, size_d)) mdata_d = wdata_d[8*i +: 8];
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= '0;
         k_q      <= '0;
         base_q   <= '0;
         wdata_q  <= '0;
         acc_q    <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cs_q     <= 1'b1;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         mdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         signed_q <= signed_d;
         size_q   <= size_d;
         k_q      <= k_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         acc_q    <= acc_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cs_q     <= cs_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         mdata_q  <= mdata_d;
      end
   end

   assign bus.RData       = rdata_q;
   assign bus.Busy        = busy_q;
   assign bus.Done        = done_q;
   assign bus.Mem_CS      = cs_q;
   assign bus.Mem_WR      = wr_q;
   assign bus.Mem_Address = addr_q;
   assign bus.Mem_Data    = mdata_q;
endmodule

// File: tb/tb_memory_transfer_unit.sv
// Directed bench for memory_transfer_unit: a little-endian and a big-endian instance run the same
// stimulus against separate byte memories; per-cycle bus values and load results come off scoreboard queues.
module tb_memory_transfer_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0, write = 1'b0, sgn = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [15:0] base = 16'h0;
   logic [31:0] wdata = 32'h0;

   logic [7:0] mem0 [65536];
   logic [7:0] mem1 [65536];

   memory_transfer_unit_if #(.ADDR_WIDTH(16), .WORD_BYTES(4)) if0 ();
   memory_transfer_unit_if #(.ADDR_WIDTH(16), .WORD_BYTES(4)) if1 ();

   assign if0.Start = start;  assign if1.Start = start;
   assign if0.Write = write;  assign if1.Write = write;
   assign if0.Signed = sgn;   assign if1.Signed = sgn;
   assign if0.Size = size;    assign if1.Size = size;
   assign if0.BaseAddr = base; assign if1.BaseAddr = base;
   assign if0.WData = wdata;  assign if1.WData = wdata;
   assign if0.MemOut = mem0[if0.Mem_Address];
   assign if1.MemOut = mem1[if1.Mem_Address];

   memory_transfer_unit #(.ADDR_WIDTH(16), .WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut0 (
      .Clock(clk), .Reset(rst_n), .bus(if0));
   memory_transfer_unit #(.ADDR_WIDTH(16), .WORD_BYTES(4), .BIG_ENDIAN(1'b1)) dut1 (
      .Clock(clk), .Reset(rst_n), .bus(if1));

   // Byte memories commit at the edge that ends a selected write cycle
   always @(posedge clk) begin
      if (!if0.Mem_CS && if0.Mem_WR) mem0[if0.Mem_Address] = if0.Mem_Data;
      if (!if1.Mem_CS && if1.Mem_WR) mem1[if1.Mem_Address] = if1.Mem_Data;
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] aq [$];
   logic [7:0]  dq0 [$];
   logic [7:0]  dq1 [$];
   logic [31:0] rq0 [$];
   logic [31:0] rq1 [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic [15:0] a, input logic [7:0] d);
      mem0[a] = d;
      mem1[a] = d;
   endtask

   // Pop expected load results and compare against both instances at the Done pulse
   task automatic check_done(input string tag);
      logic [31:0] e0, e1;
      e0 = (rq0.size() > 0) ? rq0.pop_front() : 32'hDEADBEEF;
      e1 = (rq1.size() > 0) ? rq1.pop_front() : 32'hDEADBEEF;
      chk({tag, " done0"}, 32'(if0.Done), 32'd1);
      chk({tag, " done1"}, 32'(if1.Done), 32'd1);
      chk({tag, " busy_in_done"}, 32'(if0.Busy), 32'd0);
      chk({tag, " rdata_le"}, if0.RData, e0);
      chk({tag, " rdata_be"}, if1.RData, e1);
   endtask

   // One complete transfer; per-byte expectations come from a lane model of both instances
   task automatic run(input string tag, input logic w, input logic sg, input logic [1:0] sz,
                      input logic [15:0] b, input logic [31:0] wd,
                      input logic [31:0] e0, input logic [31:0] e1);
      int busy_n;
      int cyc;
      for (int k = 0; k <= int'(sz); k++) begin
         aq.push_back(16'(b + 16'(k)));
         dq0.push_back(w ? wd[8*k +: 8] : 8'h00);
         dq1.push_back(w ? wd[8*(int'(sz)-k) +: 8] : 8'h00);
      end
      rq0.push_back(e0);
      rq1.push_back(e1);
      write = w; sgn = sg; size = sz; base = b; wdata = wd; start = 1'b1;
      tick();
      start = 1'b0;
      busy_n = 0;
      cyc = 0;
      while (if0.Busy && cyc < 16) begin
         if (aq.size() > 0) begin
            chk({tag, " addr"}, 32'(if0.Mem_Address), 32'(aq.pop_front()));
            chk({tag, " addr_be"}, 32'(if1.Mem_Address), 32'(16'(b + 16'(busy_n))));
            chk({tag, " cs"}, 32'(if0.Mem_CS), 32'd0);
            chk({tag, " wr"}, 32'(if0.Mem_WR), 32'(w));
            chk({tag, " data_le"}, 32'(if0.Mem_Data), 32'(dq0.pop_front()));
            chk({tag, " data_be"}, 32'(if1.Mem_Data), 32'(dq1.pop_front()));
         end else begin
            chk({tag, " extra_busy_cycle"}, 32'(if0.Busy), 32'd0);
         end
         busy_n++;
         cyc++;
         tick();
      end
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'(int'(sz) + 1));
      check_done(tag);
      chk({tag, " wr_after"}, 32'(if0.Mem_WR), 32'd0);
      tick();
      chk({tag, " idle_done"}, 32'(if0.Done), 32'd0);
      chk({tag, " idle_busy"}, 32'(if0.Busy), 32'd0);
      chk({tag, " idle_cs"}, 32'(if0.Mem_CS), 32'd1);
      aq.delete(); dq0.delete(); dq1.delete();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem0[i] = 8'h00;
         mem1[i] = 8'h00;
      end
      for (int i = 0; i < 4; i++) set_mem(16'(16'h0040 + i), 8'(8'h10 + i));
      set_mem(16'h0020, 8'h80);
      #22;
      // Reset values
      chk("rst rdata", if0.RData, 32'h0);
      chk("rst busy", 32'(if0.Busy), 32'd0);
      chk("rst done", 32'(if0.Done), 32'd0);
      chk("rst cs", 32'(if0.Mem_CS), 32'd1);
      chk("rst wr", 32'(if0.Mem_WR), 32'd0);
      chk("rst mdata", 32'(if0.Mem_Data), 32'd0);
      chk("rst addr", 32'(if0.Mem_Address), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      run("ld4", 1'b0, 1'b0, 2'd3, 16'h0040, 32'h0, 32'h13121110, 32'h10111213);
      run("ld1s", 1'b0, 1'b1, 2'd0, 16'h0020, 32'h0, 32'hFFFFFF80, 32'hFFFFFF80);
      run("ld1u", 1'b0, 1'b0, 2'd0, 16'h0020, 32'h0, 32'h00000080, 32'h00000080);
      set_mem(16'h0020, 8'h7F);
      set_mem(16'h0021, 8'h80);
      run("ld2s", 1'b0, 1'b1, 2'd1, 16'h0020, 32'h0, 32'hFFFF807F, 32'h00007F80);
      run("st4wrap", 1'b1, 1'b1, 2'd3, 16'hFFFE, 32'hAABBCCDD, 32'hFFFF807F, 32'h00007F80);
      chk("mem FFFE", 32'(mem0[16'hFFFE]), 32'hDD);
      chk("mem FFFF", 32'(mem0[16'hFFFF]), 32'hCC);
      chk("mem 0000", 32'(mem0[16'h0000]), 32'hBB);
      chk("mem 0001", 32'(mem0[16'h0001]), 32'hAA);
      chk("mem_be 0000", 32'(mem1[16'h0000]), 32'hCC);

      // Start pulsed during XFER is ignored and not queued
      rq0.push_back(32'h00001110);
      rq1.push_back(32'h00001011);
      write = 1'b0; sgn = 1'b0; size = 2'd1; base = 16'h0040; start = 1'b1;
      tick();
      start = 1'b1; base = 16'h0042; size = 2'd3;
      chk("ign addr0", 32'(if0.Mem_Address), 32'h0040);
      tick();
      start = 1'b0;
      chk("ign addr1", 32'(if0.Mem_Address), 32'h0041);
      tick();
      check_done("ign");
      tick();
      chk("ign no_rerun", 32'(if0.Busy), 32'd0);

      // Start held through DONE chains straight into the next transfer
      rq0.push_back(32'h00000010);
      rq1.push_back(32'h00000010);
      rq0.push_back(32'h00000011);
      rq1.push_back(32'h00000011);
      size = 2'd0; base = 16'h0040; start = 1'b1;
      tick();
      chk("b2b busy0", 32'(if0.Busy), 32'd1);
      tick();
      check_done("b2b first");
      base = 16'h0041;
      tick();
      start = 1'b0;
      chk("b2b busy1", 32'(if0.Busy), 32'd1);
      chk("b2b addr1", 32'(if0.Mem_Address), 32'h0041);
      chk("b2b done_low", 32'(if0.Done), 32'd0);
      tick();
      check_done("b2b second");
      tick();

      // Reset in the second XFER cycle of a 4-byte store aborts without a clock edge
      write = 1'b1; size = 2'd3; base = 16'h0100; wdata = 32'h11223344; start = 1'b1;
      tick();
      start = 1'b0;
      chk("abort data0", 32'(if0.Mem_Data), 32'h44);
      tick();
      chk("abort addr1", 32'(if0.Mem_Address), 32'h0101);
      #3 rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(if0.Busy), 32'd0);
      chk("abort cs", 32'(if0.Mem_CS), 32'd1);
      chk("abort wr", 32'(if0.Mem_WR), 32'd0);
      chk("abort mdata", 32'(if0.Mem_Data), 32'd0);
      chk("abort addr", 32'(if0.Mem_Address), 32'd0);
      chk("abort rdata", if0.RData, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort no_done", 32'(if0.Done | if1.Done), 32'd0);
      end
      chk("abort mem100", 32'(mem0[16'h0100]), 32'h44);
      chk("abort mem101", 32'(mem0[16'h0101]), 32'h00);
      chk("abort mem_be100", 32'(mem1[16'h0100]), 32'h11);
      rst_n = 1'b1;
      tick();
      run("post_rst", 1'b0, 1'b0, 2'd3, 16'h0040, 32'h0, 32'h13121110, 32'h10111213);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/memory_transfer_unit.md
Name: memory_transfer_unit

Overview:
Parametrised multi-byte load/store sequencer between a byte-wide memory and a word-wide datapath. It replaces hand-sequenced byte transfers through the data register and byte-select mux with one Start-driven operation. It issues 1..WORD_BYTES consecutive byte accesses from a base address, with selectable endianness and optional sign extension on loads. It sits between the address register file / ALU output and the memory.

Parameters:
ADDR_WIDTH, 16, memory address width; addresses wrap modulo 2^ADDR_WIDTH.
WORD_BYTES, 4, word width in bytes; power of two, >= 2; word width W = 8*WORD_BYTES.
BIG_ENDIAN, 0, 0: memory byte k maps to word lane k (LSB first); 1: memory byte k maps to lane Size-k.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Start  input  1  request a transfer; sampled only when Busy=0
Write  input  1  1 = store, 0 = load; latched at Start
Signed  input  1  load only: sign-extend from the top transferred byte; latched at Start
Size  input  log2(WORD_BYTES)  number of bytes minus 1; latched at Start
BaseAddr  input  ADDR_WIDTH  first byte address; latched at Start
WData  input  W  store data; latched at Start
RData  output  W  assembled load result
Busy  output  1  transfer in progress
Done  output  1  one-cycle completion pulse
Mem_Address  output  ADDR_WIDTH  memory byte address
Mem_Data  output  8  memory write byte
Mem_WR  output  1  1 = write
Mem_CS  output  1  active-low chip select
MemOut  input  8  memory read byte; combinational with Mem_Address

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - state IDLE; RData=0, Busy=0, Done=0;
  - Mem_CS=1, Mem_WR=0, Mem_Data=0, Mem_Address=0;
  - all latched operands cleared.
- Reset asserted mid-transfer aborts immediately. Bytes already written stay in memory. No Done is issued.
- The state machine has three states: IDLE, XFER, DONE.
- IDLE:
  - Busy=0, Mem_CS=1.
  - Start=1 at an edge latches Write, Signed, Size, BaseAddr and WData, clears the byte index k, clears the load accumulator, and moves to XFER.
- XFER (Busy=1), one byte per cycle:
  - Mem_Address = BaseAddr + k, truncated to ADDR_WIDTH (wraps 0xFFFF -> 0x0000 at the default width). Mem_CS=0.
  - Store: Mem_WR=1 and Mem_Data = the WData lane mapped from k; the memory commits at the edge.
  - Load: Mem_WR=0 and MemOut is captured into the mapped accumulator lane at the edge.
  - When k=Size, the edge moves to DONE; otherwise k increments.
- DONE (one cycle):
  - Done=1, Busy=0, Mem_CS=1.
  - On a load, RData was updated at the final XFER edge to the accumulator.
  - Lanes above Size are 0, or copies of the top byte's bit 7 when Signed=1.
  - Start=1 in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise the next state is IDLE.
- Latency: Start edge -> N=Size+1 XFER cycles -> Done in cycle N+1. Throughput is one transfer per N+1 cycles.
- Start while Busy=1 is ignored and not queued. Input changes during XFER have no effect.
- RData holds its last load result. Stores and ignored Starts do not change it.
- Signed is ignored for stores.
- Size=WORD_BYTES-1 transfers the full word. Sign extension then has no effect.
- Mem_Data=0 whenever Mem_WR=0.

Test Plan:
- Memory bytes 0x10..0x13 at addresses 0x0040..0x0043; load with BaseAddr=0x0040, Size=3, BIG_ENDIAN=0 -> addresses 0x40,0x41,0x42,0x43 on 4 consecutive cycles, then Done pulse, RData=0x13121110, Busy high for exactly 4 cycles.
- Same memory with BIG_ENDIAN=1 instance -> RData=0x10111213.
- Byte 0x80 at 0x0020, load Size=0, Signed=1 -> RData=0xFFFFFF80; same load with Signed=0 -> RData=0x00000080. Loading 0x7F/0x80 at 0x20/0x21 with Size=1, Signed=1 -> 0xFFFF807F.
- Store WData=0xAABBCCDD, BaseAddr=0xFFFE, Size=3 -> writes DD,CC,BB,AA to 0xFFFE,0xFFFF,0x0000,0x0001. Mem_WR=1 only in those 4 cycles. RData unchanged.
- Start pulsed during XFER -> ignored. Start held high through DONE -> second transfer begins the next cycle, with no IDLE cycle between.
- Reset dropped low in the 2nd XFER cycle of a 4-byte store -> outputs go to reset values immediately, with no clock edge needed. Only the first byte is written. No Done pulse. A new Start after Reset rises behaves normally.
